textlcd_responder: RTL
======================

# textlcd_responder

Character-LCD responder: the receiving end of the HD44780-style bus driven by the team's text-LCD controller. It samples `lcd_rs`/`lcd_rw`/`lcd_en`/`lcd_data` on `lcdclk` and decodes instructions and data writes into a 128-byte DDRAM. It answers busy-flag and data reads, and exposes two 16-character display windows. It serves as the on-chip mirror and closed-loop checker for the LCD path.

## Interface
- `BUSY_CYCLES`, default 40: busy duration after a normal instruction, data write or data read.
- `CLEAR_CYCLES`, default 1520: busy duration after clear or return-home; must be ≥ 128.
- `LINE2_BASE`, default 7'h28: DDRAM address of the first character of `line2_text`.
- `lcdclk`  in  1  clock; the same domain as the bus driver.
- `resetn`  in  1  reset; asynchronous, active-low.
- `lcd_rs`, `lcd_rw`, `lcd_en`  in  1 each  bus register select, read/write and enable.
- `lcd_data_in`  in  8  bus data from the controller.
- `lcd_data_out`  out  8  read data; reset 0.
- `lcd_data_oe`  out  1  read-data drive enable; reset 0.
- `line1_text`  out  128  DDRAM[0..15]; first char in [127:120]; reset all 8'h20.
- `line2_text`  out  128  DDRAM[LINE2_BASE..+15]; first char in [127:120]; reset all 8'h20.
- `addr_cnt`  out  7  address counter (AC); reset 0.
- `busy`  out  1  busy flag; reset 0.
- `display_on`, `cursor_on`, `blink_on`  out  1 each  display control bits; reset 0.
- `entry_inc`  out  1  I/D bit; reset 1.
- `entry_shift`  out  1  S bit; reset 0.
- `func_bits`  out  3  function set {DL,N,F}; reset 0.
- `overrun`  out  1  sticky flag, cleared only by reset; reset 0.

## Operation
- Transaction is accepted on a falling edge of E: `en_q`=1 and `lcd_en`=0 in the same cycle. `rs`, `rw` and data are taken from that cycle.
- States: IDLE, BUSY, CLEAR.
    - IDLE → BUSY on any accepted transaction, except status reads.
    - IDLE → CLEAR on instruction 0x01.
    - CLEAR → BUSY after 128 cycles.
    - BUSY → IDLE when the busy counter expires.
- Instruction decode (rs=0, rw=0) is by the highest set bit:
    - 0x01 clear: every DDRAM byte ← 0x20, one address per cycle; AC=0; entry_inc=1.
    - 0x02/0x03 return home: AC=0.
    - 0x04–0x07 entry mode: entry_inc=d[1], entry_shift=d[0]; entry_shift is stored only.
    - 0x08–0x0F display control: display_on=d[2], cursor_on=d[1], blink_on=d[0].
    - 0x10–0x1F cursor/display shift: if d[3]=0, AC ±1 (d[2]=1 increments); if d[3]=1, ignored apart from busy.
    - 0x20–0x3F function set: func_bits=d[4:2].
    - 0x40–0x7F set CGRAM address: no state change apart from busy.
    - 0x80–0xFF set DDRAM address: AC=d[6:0].
- Data write (rs=1, rw=0): DDRAM[AC]=data, then AC ±1 per entry_inc.
- All AC arithmetic is modulo 128: 0x7F+1=0x00, 0x00−1=0x7F.
- Status read (rs=0, rw=1):
    - returns {busy, AC};
    - allowed while busy; never sets overrun; never starts busy.
- Data read (rs=1, rw=1): returns DDRAM[AC]; AC ±1 on the falling edge; starts BUSY_CYCLES.
- Any accepted transaction other than a status read while busy=1 is dropped and sets overrun=1.
- Reset mid-CLEAR: everything returns to reset values; DDRAM is all 0x20.

## Timing
- Falling edge detected in cycle N: register and AC updates are visible at N+1.
- busy=1 from N+1 for exactly BUSY_CYCLES cycles, or CLEAR_CYCLES for 0x01/0x02/0x03.
- Clear: DDRAM[i] becomes 0x20 at cycle N+1+i, for i = 0..127.
- `line1_text`/`line2_text` follow DDRAM with zero additional latency (combinational from DDRAM registers).
- Read path:
    - `lcd_data_oe` is registered: lcd_en & lcd_rw, one cycle late.
    - `lcd_data_out` is registered each cycle while lcd_en=1 and rw=1, one cycle late.
- A 2000-cycle bus period with E high for cycles 200–1800 satisfies both busy times with default parameters.

## Configuration
- `TEXTLCD_RESP_READ_EN` defined: status and data reads are implemented as described above.
- `TEXTLCD_RESP_READ_EN` undefined:
    - `lcd_data_out`=0 and `lcd_data_oe`=0 permanently;
    - rw=1 transactions are ignored entirely: no AC change, no busy, no overrun.

## Structure
- Package `textlcd_pkg` holds:
    - state enum (IDLE/BUSY/CLEAR);
    - SPACE=8'h20;
    - DDRAM_DEPTH=128;
    - instruction opcode masks.
- Sub-module `textlcd_ddram` is a 128×8 register file with:
    - one write port;
    - one random read port;
    - two 16-byte window outputs;
    - async reset to 0x20.
- The top level contains edge detection, decode, the state machine, the busy counter and AC.

## Test plan
- Reset → `line1_text`=128'h2020…20, busy=0, addr_cnt=0, entry_inc=1, lcd_data_oe=0.
- Controller-timed sequence 0x38, 0x0E, 0x06, 0x02, 0x01, 0x80, then data 'T','e','x','t' →
    - line1_text[127:96]=32'h54657874;
    - display_on=1, cursor_on=1, blink_on=0;
    - func_bits=3'b110;
    - addr_cnt=4.
- Instruction 0xA8 then data 0x53 → DDRAM[0x28]=0x53, line2_text[127:120]=8'h53, addr_cnt=7'h29.
- Instruction 0x01 after writes →
    - busy high exactly CLEAR_CYCLES cycles;
    - all windows 0x20;
    - addr_cnt=0, entry_inc=1;
    - overrun stays 0.
- Two data writes 20 cycles apart → second write dropped; DDRAM unchanged at the new AC; overrun=1 until reset.
- Read scenario (`TEXTLCD_RESP_READ_EN` defined):
    - status read while busy → lcd_data_out={1'b1, AC}, lcd_data_oe=1;
    - data read at AC=0 after "Text" → 0x54, addr_cnt=1;
    - instruction 0xFF then one data write → addr_cnt wraps to 0x00.

Source files
------------

// File: rtl/textlcd_pkg.sv
// rtl/textlcd_pkg.sv - shared types, constants and instruction decode for the text-LCD responder
//
// Purpose: state encoding, DDRAM constants, HD44780 opcode masks and a
// helper that classifies an instruction byte by its highest set bit.
// Ports: none (package).
package textlcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam logic [7:0] SPACE       = 8'h20;
  localparam int         DDRAM_DEPTH = 128;

  localparam logic [7:0] OP_MASK_DDRAM   = 8'h80;
  localparam logic [7:0] OP_MASK_CGRAM   = 8'h40;
  localparam logic [7:0] OP_MASK_FUNC    = 8'h20;
  localparam logic [7:0] OP_MASK_SHIFT   = 8'h10;
  localparam logic [7:0] OP_MASK_DISPLAY = 8'h08;
  localparam logic [7:0] OP_MASK_ENTRY   = 8'h04;
  localparam logic [7:0] OP_MASK_HOME    = 8'h02;
  localparam logic [7:0] OP_MASK_CLEAR   = 8'h01;

  typedef enum logic [3:0] {
    OP_NONE,
    OP_CLEAR,
    OP_HOME,
    OP_ENTRY,
    OP_DISPLAY,
    OP_SHIFT,
    OP_FUNC,
    OP_CGRAM,
    OP_DDRAM
  } op_t;

  // The instruction class is the highest set bit, so test from the top down.
  function automatic op_t decode_op(input logic [7:0] d);
    if ((d & OP_MASK_DDRAM) != 8'h00)   return OP_DDRAM;
    if ((d & OP_MASK_CGRAM) != 8'h00)   return OP_CGRAM;
    if ((d & OP_MASK_FUNC) != 8'h00)    return OP_FUNC;
    if ((d & OP_MASK_SHIFT) != 8'h00)   return OP_SHIFT;
    if ((d & OP_MASK_DISPLAY) != 8'h00) return OP_DISPLAY;
    if ((d & OP_MASK_ENTRY) != 8'h00)   return OP_ENTRY;
    if ((d & OP_MASK_HOME) != 8'h00)    return OP_HOME;
    if ((d & OP_MASK_CLEAR) != 8'h00)   return OP_CLEAR;
    return OP_NONE;
  endfunction

endpackage

// File: rtl/textlcd_responder_if.sv
// rtl/textlcd_responder_if.sv - HD44780-style character-LCD bus
//
// Purpose: bundles the LCD bus between the text-LCD controller (master)
// and the responder (slave).
// Signals: lcd_rs/lcd_rw/lcd_en/lcd_data_in driven by the master;
// lcd_data_out/lcd_data_oe driven by the slave during reads.
interface textlcd_responder_if;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data_in;
  logic [7:0] lcd_data_out;
  logic       lcd_data_oe;

  modport master (
    output lcd_rs, lcd_rw, lcd_en, lcd_data_in,
    input  lcd_data_out, lcd_data_oe
  );

  modport slave (
    input  lcd_rs, lcd_rw, lcd_en, lcd_data_in,
    output lcd_data_out, lcd_data_oe
  );
endinterface

// File: rtl/textlcd_ddram.sv
// rtl/textlcd_ddram.sv - 128x8 display data RAM with two 16-character windows
//
// Purpose: register-file DDRAM, reset asynchronously to spaces.
// Ports: lcdclk/resetn clock and async active-low reset; wr_en/wr_addr/
// wr_data single write port; rd_addr/rd_data combinational read port;
// line1/line2 16-byte windows at address 0 and LINE2_BASE, first
// character in [127:120].
module textlcd_ddram
  import textlcd_pkg::*;
#(
  parameter logic [6:0] LINE2_BASE = 7'h28
) (
  input  logic         lcdclk,
  input  logic         resetn,
  input  logic         wr_en,
  input  logic [6:0]   wr_addr,
  input  logic [7:0]   wr_data,
  input  logic [6:0]   rd_addr,
  output logic [7:0]   rd_data,
  output logic [127:0] line1,
  output logic [127:0] line2
);

  logic [7:0] mem [DDRAM_DEPTH];

  always_ff @(posedge lcdclk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DDRAM_DEPTH; i++) mem[i] <= SPACE;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

  // The second window wraps modulo 128 like every other DDRAM address.
  always_comb begin
    line1 = '0;
    line2 = '0;
    for (int k = 0; k < 16; k++) begin
      line1[127-8*k -: 8] = mem[7'(k)];
      line2[127-8*k -: 8] = mem[LINE2_BASE + 7'(k)];
    end
  end

endmodule

// File: rtl/textlcd_responder.sv
// rtl/textlcd_responder.sv - receiving end of the HD44780-style text-LCD bus
//
// Purpose: samples the LCD bus, accepts a transaction on each falling edge
// of E, decodes instructions and data writes into DDRAM, models the busy
// flag and exposes two display windows.
// Ports: lcdclk clock, resetn async active-low reset; bus (slave modport)
// carries the LCD bus; line1_text/line2_text display windows; addr_cnt
// address counter; busy flag; display_on/cursor_on/blink_on, entry_inc/
// entry_shift, func_bits mirrored control state; overrun sticky flag for
// transactions dropped while busy.
// Build option: TEXTLCD_RESP_READ_EN enables status and data reads; without
// it the read outputs stay 0 and rw=1 transactions are ignored.
module textlcd_responder
  import textlcd_pkg::*;
#(
  parameter int         BUSY_CYCLES  = 40,
  parameter int         CLEAR_CYCLES = 1520,
  parameter logic [6:0] LINE2_BASE   = 7'h28
) (
  input  logic                lcdclk,
  input  logic                resetn,
  textlcd_responder_if.slave  bus,
  output logic [127:0]        line1_text,
  output logic [127:0]        line2_text,
  output logic [6:0]          addr_cnt,
  output logic                busy,
  output logic                display_on,
  output logic                cursor_on,
  output logic                blink_on,
  output logic                entry_inc,
  output logic                entry_shift,
  output logic [2:0]          func_bits,
  output logic                overrun
);

  localparam int CNT_W = $clog2(CLEAR_CYCLES + 1);

  state_t           state;
  logic             en_q;
  logic [CNT_W-1:0] busy_cnt;
  logic [6:0]       clr_cnt;

  logic       fall;
  logic       take;
  logic       status_rd;
  logic       accept;
  logic       drop;
  op_t        op;
  logic [6:0] ac_step;

  logic       wr_en;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;

  assign fall = en_q & ~bus.lcd_en;

`ifdef TEXTLCD_RESP_READ_EN
  assign take = fall;
`else
  // Without read support an rw=1 cycle is invisible to the responder.
  assign take = fall & ~bus.lcd_rw;
`endif

  assign status_rd = take & ~bus.lcd_rs & bus.lcd_rw;
  assign accept    = take & ~status_rd & (state == IDLE);
  assign drop      = take & ~status_rd & (state != IDLE);
  assign op        = decode_op(bus.lcd_data_in);
  assign ac_step   = entry_inc ? addr_cnt + 7'd1 : addr_cnt - 7'd1;

  // Clear writes address 0 on the accepting edge itself and then walks the
  // rest of the array from CLEAR, so byte i is a space from cycle N+1+i.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = addr_cnt;
    wr_data = bus.lcd_data_in;
    if (state == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clr_cnt;
      wr_data = SPACE;
    end else if (accept && !bus.lcd_rw) begin
      if (bus.lcd_rs) begin
        wr_en = 1'b1;
      end else if (op == OP_CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = 7'd0;
        wr_data = SPACE;
      end
    end
  end

  textlcd_ddram #(
    .LINE2_BASE (LINE2_BASE)
  ) u_ddram (
    .lcdclk  (lcdclk),
    .resetn  (resetn),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (addr_cnt),
    .rd_data (rd_data),
    .line1   (line1_text),
    .line2   (line2_text)
  );

  always_ff @(posedge lcdclk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      en_q        <= 1'b0;
      busy        <= 1'b0;
      busy_cnt    <= '0;
      clr_cnt     <= 7'd0;
      addr_cnt    <= 7'd0;
      display_on  <= 1'b0;
      cursor_on   <= 1'b0;
      blink_on    <= 1'b0;
      entry_inc   <= 1'b1;
      entry_shift <= 1'b0;
      func_bits   <= 3'b000;
      overrun     <= 1'b0;
    end else begin
      en_q <= bus.lcd_en;
      if (drop) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (accept) begin
            state    <= BUSY;
            busy     <= 1'b1;
            busy_cnt <= CNT_W'(BUSY_CYCLES - 1);
            if (!bus.lcd_rs) begin
              // rs=0 that gets accepted is always an instruction write.
              case (op)
                OP_CLEAR: begin
                  state     <= CLEAR;
                  clr_cnt   <= 7'd1;
                  addr_cnt  <= 7'd0;
                  entry_inc <= 1'b1;
                end
                OP_HOME: begin
                  addr_cnt <= 7'd0;
                  busy_cnt <= CNT_W'(CLEAR_CYCLES - 1);
                end
                OP_ENTRY: begin
                  entry_inc   <= bus.lcd_data_in[1];
                  entry_shift <= bus.lcd_data_in[0];
                end
                OP_DISPLAY: begin
                  display_on <= bus.lcd_data_in[2];
                  cursor_on  <= bus.lcd_data_in[1];
                  blink_on   <= bus.lcd_data_in[0];
                end
                OP_SHIFT: begin
                  if (!bus.lcd_data_in[3]) begin
                    addr_cnt <= bus.lcd_data_in[2] ? addr_cnt + 7'd1 : addr_cnt - 7'd1;
                  end
                end
                OP_FUNC:  func_bits <= bus.lcd_data_in[4:2];
                OP_DDRAM: addr_cnt  <= bus.lcd_data_in[6:0];
                default: ;
              endcase
            end else begin
              // Data write or data read: both advance AC.
              addr_cnt <= ac_step;
            end
          end
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + 7'd1;
          // clr_cnt wraps to 0 in the 128th CLEAR cycle; the remainder of
          // the clear busy time is then spent in BUSY.
          if (clr_cnt == 7'd0) begin
            if (CLEAR_CYCLES > DDRAM_DEPTH) begin
              state    <= BUSY;
              busy_cnt <= CNT_W'(CLEAR_CYCLES - DDRAM_DEPTH - 1);
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        BUSY: begin
          if (busy_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            busy_cnt <= busy_cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef TEXTLCD_RESP_READ_EN
  always_ff @(posedge lcdclk or negedge resetn) begin
    if (!resetn) begin
      bus.lcd_data_oe  <= 1'b0;
      bus.lcd_data_out <= 8'h00;
    end else begin
      bus.lcd_data_oe <= bus.lcd_en & bus.lcd_rw;
      if (bus.lcd_en && bus.lcd_rw) begin
        bus.lcd_data_out <= bus.lcd_rs ? rd_data : {busy, addr_cnt};
      end
    end
  end
`else
  logic unused_rd_data;
  assign unused_rd_data   = ^rd_data;
  assign bus.lcd_data_oe  = 1'b0;
  assign bus.lcd_data_out = 8'h00;
`endif

endmodule
